// File: rtl/serial_tx_pkg.sv
// Shared types for the serial word transmitter.
//   tx_state_t : frame FSM states (IDLE, CLEAR, SHIFT, GAP)
package serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } tx_state_t;

endpackage

// File: rtl/serial_word_tx_if.sv
// Bundle of the word handshake and the serial/detector-side outputs.
//   in_data/in_valid/in_ready : parallel word handshake (producer -> transmitter)
//   x/bit_valid/last_bit      : serial bit stream, MSB first
//   det_rst_n                 : active-low detector clear, one pulse per frame
//   busy                      : frame in progress
// master = word producer / detector side, slave = transmitter.
interface serial_word_tx_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             x;
   logic             bit_valid;
   logic             last_bit;
   logic             det_rst_n;
   logic             busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, x, bit_valid, last_bit, det_rst_n, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, x, bit_valid, last_bit, det_rst_n, busy
   );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register, MSB first.
//   clk, rst   : clock, synchronous active-high reset (clears the register)
//   load_i     : capture d_i (takes priority over shift_en_i)
//   shift_en_i : shift left by one, zero fill
//   d_i        : parallel word
//   msb_o      : current MSB, registered
module piso_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = d_i;
      end else if (shift_en_i) begin
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_word_tx.sv
// Serial word transmitter: accepts a WIDTH-bit word on a valid/ready handshake,
// pulses the detector clear for one cycle, then shifts the word out MSB first,
// followed by GAP_CYCLES idle cycles.
//   clk    : clock, all logic on posedge
//   rst    : synchronous active-high reset; aborts any frame in progress
//   bus_io : word handshake in, serial bit stream and detector clear out
module serial_word_tx
   import serial_tx_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   serial_word_tx_if.slave        bus_io
);

   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam int unsigned     GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CntW-1:0] BitLast = CntW'(WIDTH - 1);
   localparam logic [GapW-1:0] GapLast = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

   tx_state_t       state_q, state_d;
   logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
   logic            load, shift_en, msb;

   piso_shift_reg #(
      .WIDTH (WIDTH)
   ) u_piso (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .shift_en_i (shift_en),
      .d_i        (bus_io.in_data),
      .msb_o      (msb)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      load      = 1'b0;
      shift_en  = 1'b0;
      case (state_q)
         IDLE: begin
            // in_ready is high throughout IDLE, so in_valid alone completes the handshake
            if (bus_io.in_valid) begin
               load    = 1'b1;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (bit_cnt_q == BitLast) begin
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GapLast) begin
               gap_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // Outputs decode registered state only; rst also holds the detector clear
   // low so the detector is wiped together with an aborted frame.
   always_comb begin
      bus_io.in_ready  = (state_q == IDLE);
      bus_io.bit_valid = (state_q == SHIFT);
      bus_io.x         = (state_q == SHIFT) & msb;
      bus_io.last_bit  = (state_q == SHIFT) && (bit_cnt_q == BitLast);
      bus_io.det_rst_n = ~(rst | (state_q == CLEAR));
      bus_io.busy      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_word_tx_if #(.WIDTH(8)) bus_a ();
   serial_word_tx_if #(.WIDTH(8)) bus_b ();

   serial_word_tx #(.WIDTH(8), .GAP_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus_io(bus_a));
   serial_word_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus_io(bus_b));

   // Observed frames, reassembled from the serial stream
   logic [7:0] rx_a[$], rx_b[$];
   int rx_cyc_a[$], first_cyc_a[$], clr_cyc_a[$];
   int first_cyc_b[$], clr_cyc_b[$];
   bit y2_a[$], y3_a[$];
   int viol_a = 0, viol_b = 0;
   int nb_a = 0, nb_b = 0, r2 = 0, r3 = 0;
   logic [7:0] sh_a = '0, sh_b = '0;

   // Monitor A, with divisible-by-2 and divisible-by-3 detector models
   always @(negedge clk) begin
      if (rst) begin
         nb_a = 0;
      end else begin
         if (bus_a.bit_valid !== 1'b1 && bus_a.x !== 1'b0) viol_a++;
         if (bus_a.last_bit === 1'b1 && bus_a.bit_valid !== 1'b1) viol_a++;
         if (bus_a.det_rst_n === 1'b0) begin
            clr_cyc_a.push_back(cyc);
            r2 = 0;
            r3 = 0;
         end
         if (bus_a.bit_valid === 1'b1) begin
            if (nb_a == 0) first_cyc_a.push_back(cyc);
            sh_a = {sh_a[6:0], bus_a.x};
            nb_a++;
            r2 = (r2 * 2 + int'(bus_a.x)) % 2;
            r3 = (r3 * 2 + int'(bus_a.x)) % 3;
            if (bus_a.last_bit === 1'b1) begin
               if (nb_a != 8) viol_a++;
               rx_a.push_back(sh_a);
               rx_cyc_a.push_back(cyc);
               y2_a.push_back(r2 == 0);
               y3_a.push_back(r3 == 0);
               nb_a = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         nb_b = 0;
      end else begin
         if (bus_b.bit_valid !== 1'b1 && bus_b.x !== 1'b0) viol_b++;
         if (bus_b.last_bit === 1'b1 && bus_b.bit_valid !== 1'b1) viol_b++;
         if (bus_b.det_rst_n === 1'b0) clr_cyc_b.push_back(cyc);
         if (bus_b.bit_valid === 1'b1) begin
            if (nb_b == 0) first_cyc_b.push_back(cyc);
            sh_b = {sh_b[6:0], bus_b.x};
            nb_b++;
            if (bus_b.last_bit === 1'b1) begin
               if (nb_b != 8) viol_b++;
               rx_b.push_back(sh_b);
               nb_b = 0;
            end
         end
      end
   end

   task automatic clear_mon();
      rx_a.delete(); rx_cyc_a.delete(); first_cyc_a.delete(); clr_cyc_a.delete();
      y2_a.delete(); y3_a.delete();
      rx_b.delete(); first_cyc_b.delete(); clr_cyc_b.delete();
   endtask

   // Handshake one word on A; hs is the cycle index just before the accepting edge
   task automatic send_a(input logic [7:0] w, output int hs, output bit ok);
      ok = 1'b0;
      hs = 0;
      @(posedge clk); #1;
      bus_a.in_data  = w;
      bus_a.in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_a.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      hs = cyc;
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = 8'($urandom);
   endtask

   task automatic wait_rx_a(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rx_a.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle_a(output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus_a.in_ready === 1'b1) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_a.in_valid = 1'b0; bus_a.in_data = '0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus_a.in_ready, bus_a.bit_valid, bus_a.x, bus_a.busy, bus_a.last_bit, bus_a.det_rst_n}
          !== 6'b100000)
         $display("FAIL reset_a: rdy,bv,x,busy,last,drn got %b want 100000",
                  {bus_a.in_ready, bus_a.bit_valid, bus_a.x, bus_a.busy, bus_a.last_bit,
                   bus_a.det_rst_n});
      else n_pass++;
      n_checks++;
      if ({bus_b.in_ready, bus_b.bit_valid, bus_b.x, bus_b.busy, bus_b.last_bit, bus_b.det_rst_n}
          !== 6'b100000)
         $display("FAIL reset_b: rdy,bv,x,busy,last,drn got %b want 100000",
                  {bus_b.in_ready, bus_b.bit_valid, bus_b.x, bus_b.busy, bus_b.last_bit,
                   bus_b.det_rst_n});
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus_a.det_rst_n, bus_b.det_rst_n, bus_a.in_ready, bus_a.busy} !== 4'b1110)
         $display("FAIL reset_release: drn_a,drn_b,rdy_a,busy_a got %b want 1110",
                  {bus_a.det_rst_n, bus_b.det_rst_n, bus_a.in_ready, bus_a.busy});
      else n_pass++;
   endtask

   task automatic test_single();
      int hs, at;
      bit ok, ok2;
      clear_mon();
      send_a(8'hA6, hs, ok);
      @(negedge clk);
      n_checks++;
      if ({bus_a.busy, bus_a.det_rst_n, bus_a.bit_valid, bus_a.in_ready} !== 4'b1000)
         $display("FAIL single_clear_cycle: busy,drn,bv,rdy got %b want 1000",
                  {bus_a.busy, bus_a.det_rst_n, bus_a.bit_valid, bus_a.in_ready});
      else n_pass++;
      wait_rx_a(1, ok2);
      wait_idle_a(at, ok);
      n_checks++;
      if (!(ok && ok2) || rx_a.size() != 1 || rx_a[0] !== 8'hA6)
         $display("FAIL single_word: got %0h (frames %0d) want a6", ok2 ? rx_a[0] : 8'hxx,
                  rx_a.size());
      else n_pass++;
      n_checks++;
      if (!ok2 || first_cyc_a[0] != hs + 2 || rx_cyc_a[0] != hs + 9)
         $display("FAIL single_bit_timing: msb/lsb cycle got %0d/%0d want %0d/%0d",
                  ok2 ? first_cyc_a[0] - hs : -1, ok2 ? rx_cyc_a[0] - hs : -1, 2, 9);
      else n_pass++;
      n_checks++;
      if (clr_cyc_a.size() != 1 || clr_cyc_a[0] != hs + 1)
         $display("FAIL single_clear: pulses got %0d want 1 at offset 1", clr_cyc_a.size());
      else n_pass++;
      n_checks++;
      if (!ok || at - hs != 11)
         $display("FAIL single_ready_back: offset got %0d want 11", ok ? at - hs : -1);
      else n_pass++;
   endtask

   task automatic test_divisible();
      logic [7:0] ws[6];
      int hs;
      bit ok, all_ok;
      clear_mon();
      ws[0] = 8'h0C;
      ws[1] = 8'h0B;
      for (int i = 2; i < 6; i++) ws[i] = 8'($urandom);
      all_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_a(ws[i], hs, ok);
         all_ok &= ok;
      end
      wait_rx_a(6, ok);
      n_checks++;
      if (!(ok && all_ok)) $display("FAIL div_frames: got %0d frames want 6", rx_a.size());
      else n_pass++;
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rx_a[i] !== ws[i] || y2_a[i] !== (ws[i] % 2 == 0) || y3_a[i] !== (ws[i] % 3 == 0))
               $display("FAIL div_word%0d: word %0h y2 %0b y3 %0b want %0h %0b %0b", i, rx_a[i],
                        y2_a[i], y3_a[i], ws[i], ws[i] % 2 == 0, ws[i] % 3 == 0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ws[3];
      int hs[3];
      bit ok, all_ok;
      clear_mon();
      for (int i = 0; i < 3; i++) ws[i] = 8'($urandom);
      all_ok = 1'b1;
      @(posedge clk); #1;
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = ws[0];
      for (int i = 0; i < 3; i++) begin
         ok = 1'b0;
         for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus_b.in_ready === 1'b1) begin
               ok = 1'b1;
               break;
            end
         end
         all_ok &= ok;
         hs[i] = cyc;
         @(posedge clk); #1;
         bus_b.in_data = (i < 2) ? ws[i+1] : 8'($urandom);
      end
      bus_b.in_valid = 1'b0;
      repeat (12) @(negedge clk);
      n_checks++;
      if (!all_ok || rx_b.size() != 3)
         $display("FAIL b2b_frames: got %0d frames want 3", rx_b.size());
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rx_b.size() != 3 || rx_b[i] !== ws[i] || clr_cyc_b[i] != hs[i] + 1 ||
             first_cyc_b[i] != hs[i] + 2)
            $display("FAIL b2b_word%0d: got %0h want %0h (clear/msb at hs+1/hs+2)", i,
                     rx_b.size() == 3 ? rx_b[i] : 8'hxx, ws[i]);
         else n_pass++;
      end
      for (int i = 1; i < 3; i++) begin
         n_checks++;
         if (hs[i] - hs[i-1] != 10)
            $display("FAIL b2b_spacing%0d: got %0d want 10", i, hs[i] - hs[i-1]);
         else n_pass++;
      end
   endtask

   task automatic test_ignore();
      logic [7:0] w;
      int hs, at, bad;
      bit ok, ok2;
      clear_mon();
      w = 8'($urandom);
      bad = 0;
      send_a(w, hs, ok);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus_a.in_ready !== 1'b0) bad++;
         @(posedge clk); #1;
         bus_a.in_valid = 1'($urandom);
         bus_a.in_data  = 8'($urandom);
      end
      bus_a.in_valid = 1'b0;
      wait_idle_a(at, ok2);
      repeat (15) @(negedge clk);
      n_checks++;
      if (bad != 0) $display("FAIL ignore_ready_low: in_ready high %0d times want 0", bad);
      else n_pass++;
      n_checks++;
      if (!(ok && ok2) || rx_a.size() != 1 || rx_a[0] !== w || clr_cyc_a.size() != 1)
         $display("FAIL ignore_word: frames %0d clears %0d word %0h want 1 1 %0h", rx_a.size(),
                  clr_cyc_a.size(), rx_a.size() > 0 ? rx_a[0] : 8'hxx, w);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] w;
      int hs;
      bit ok, ok2;
      clear_mon();
      send_a(8'hFF, hs, ok);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (!ok || {bus_a.bit_valid, bus_a.x, bus_a.det_rst_n} !== 3'b110)
         $display("FAIL mid_rst_bit4: bv,x,drn got %b want 110",
                  {bus_a.bit_valid, bus_a.x, bus_a.det_rst_n});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({bus_a.x, bus_a.bit_valid, bus_a.last_bit, bus_a.busy, bus_a.in_ready} !== 5'b00001)
         $display("FAIL mid_rst_abort: x,bv,last,busy,rdy got %b want 00001",
                  {bus_a.x, bus_a.bit_valid, bus_a.last_bit, bus_a.busy, bus_a.in_ready});
      else n_pass++;
      n_checks++;
      if (rx_a.size() != 0) $display("FAIL mid_rst_partial: frames got %0d want 0", rx_a.size());
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      w = 8'($urandom);
      send_a(w, hs, ok);
      wait_rx_a(1, ok2);
      n_checks++;
      if (!(ok && ok2) || rx_a[0] !== w || first_cyc_a[0] != hs + 2)
         $display("FAIL mid_rst_resume: got %0h want %0h", ok2 ? rx_a[0] : 8'hxx, w);
      else n_pass++;
   endtask

   task automatic test_invariants();
      n_checks++;
      if (viol_a != 0 || viol_b != 0)
         $display("FAIL invariants: x/last_bit/bit-count violations a=%0d b=%0d want 0 0",
                  viol_a, viol_b);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_divisible();
      test_back_to_back();
      test_ignore();
      test_reset_mid();
      repeat (5) @(negedge clk);
      test_invariants();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
